// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample path: data width, error codes and
// the sample record carried through the input buffer.
package fir_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;

  typedef struct packed {
    logic [1:0]        error;
    logic [DATA_W-1:0] data;
  } sample_t;

endpackage

// File: rtl/ad_data_in_module_if.sv
// Avalon-ST link between the ADC capture block (source) and the FIR sink.
interface ad_data_in_module_if;
  import fir_pkg::*;

  logic [DATA_W-1:0] ast_source_data;
  logic              ast_source_valid;
  logic              ast_source_ready;
  logic [1:0]        ast_source_error;

  modport master (
    output ast_source_data,
    output ast_source_valid,
    output ast_source_error,
    input  ast_source_ready
  );

  modport slave (
    input  ast_source_data,
    input  ast_source_valid,
    input  ast_source_error,
    output ast_source_ready
  );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on rd_data.
// A push while full is only taken when a pop frees the head slot in the same
// cycle; otherwise it is ignored and the parent decides what a drop means.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  // Storage and pointer update; entries are cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad_data_in_module.sv
// Pipelined ADC capture front end. Generates the ADC conversion clock,
// samples the parallel bus at a fixed divider phase, discards the ADC's
// pipeline fill after reset, optionally converts offset-binary to two's
// complement, and buffers samples so FIR backpressure is honoured. When a
// sample is lost to a full buffer, the next stored word is tagged ERR_OVF.
module ad_data_in_module
  import fir_pkg::*;
#(
  parameter int CLK_DIV       = 8,
  parameter int CAPTURE_PHASE = 6,
  parameter int PIPE_SKIP     = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int SIGNED_OUT    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] AD_Data,
  output logic              AD_CLK,
  ad_data_in_module_if.master ast
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int SKIP_W = (PIPE_SKIP < 1) ? 1 : $clog2(PIPE_SKIP + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0]  PHASE     = CNT_W'(CAPTURE_PHASE);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(PIPE_SKIP);
  localparam logic [DATA_W-1:0] MSB_FLIP  =
    (SIGNED_OUT != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  logic [CNT_W-1:0]  cnt;
  logic [SKIP_W-1:0] skip_cnt;
  logic              ovf;
  logic              strobe;
  logic              push_req;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  sample_t           wr_sample;
  sample_t           rd_sample;

  // Capture strobe, push/pop decisions and the word presented to the buffer.
  always_comb begin
    strobe          = (cnt == PHASE);
    push_req        = strobe && (skip_cnt == '0);
    pop             = !fifo_empty && ast.ast_source_ready;
    accept          = push_req && (!fifo_full || pop);
    drop            = push_req && fifo_full && !pop;
    wr_sample.data  = AD_Data ^ MSB_FLIP;
    wr_sample.error = ovf ? ERR_OVF : ERR_NONE;
  end

  // Divider, registered conversion clock, pipeline-fill skip and overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      AD_CLK   <= 1'b0;
      skip_cnt <= SKIP_INIT;
      ovf      <= 1'b0;
    end else begin
      cnt    <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      AD_CLK <= (cnt < CNT_HALF);
      if (strobe && (skip_cnt != '0)) begin
        skip_cnt <= skip_cnt - 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (accept) begin
        ovf <= 1'b0;
      end
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(sample_t))
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push_req),
    .pop     (pop),
    .wr_data (wr_sample),
    .rd_data (rd_sample),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ast.ast_source_valid = !fifo_empty;
  assign ast.ast_source_data  = rd_sample.data;
  assign ast.ast_source_error = rd_sample.error;

endmodule

// File: tb/tb_ad_data_in_module.sv
// Bench for ad_data_in_module: two instances (signed and unsigned output)
// share stimulus; a queue-based model of the capture rules runs alongside.
module tb_ad_data_in_module;
  import fir_pkg::*;

  localparam int CLK_DIV       = 8;
  localparam int CAPTURE_PHASE = 6;
  localparam int PIPE_SKIP     = 3;
  localparam int FIFO_DEPTH    = 4;

  typedef struct {
    int         cyc;
    logic       clk_e;
    logic       valid_e;
    logic       chk_data;
    logic [7:0] data_e;
    logic [1:0] err_e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] ad_data;
  logic       ad_clk_s;
  logic       ad_clk_u;

  ad_data_in_module_if ast_s ();
  ad_data_in_module_if ast_u ();

  assign ast_s.ast_source_ready = ready;
  assign ast_u.ast_source_ready = ready;

  ad_data_in_module #(
    .CLK_DIV(CLK_DIV), .CAPTURE_PHASE(CAPTURE_PHASE), .PIPE_SKIP(PIPE_SKIP),
    .FIFO_DEPTH(FIFO_DEPTH), .SIGNED_OUT(1)
  ) dut_s (
    .CLK(clk), .RST(rst), .AD_Data(ad_data), .AD_CLK(ad_clk_s), .ast(ast_s)
  );

  ad_data_in_module #(
    .CLK_DIV(CLK_DIV), .CAPTURE_PHASE(CAPTURE_PHASE), .PIPE_SKIP(PIPE_SKIP),
    .FIFO_DEPTH(FIFO_DEPTH), .SIGNED_OUT(0)
  ) dut_u (
    .CLK(clk), .RST(rst), .AD_Data(ad_data), .AD_CLK(ad_clk_u), .ast(ast_u)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         m_cyc    = 0;
  bit         m_ovf    = 1'b0;
  logic [7:0] q_data[$];
  logic [1:0] q_err[$];

  function automatic logic [7:0] dval(input int c);
    return 8'(c * 7 + 3);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: samples arrive every CLK_DIV cycles at CAPTURE_PHASE, the first
  // PIPE_SKIP are thrown away, a queue of at most FIFO_DEPTH holds the rest.
  task automatic modelStep(input logic r, input logic [7:0] d, input logic rdy);
    bit pop_m;
    bit push_m;
    if (r) begin
      q_data.delete();
      q_err.delete();
      m_ovf = 1'b0;
      m_cyc = 0;
    end else begin
      pop_m  = (q_data.size() > 0) && rdy;
      push_m = ((m_cyc % CLK_DIV) == CAPTURE_PHASE) && ((m_cyc / CLK_DIV) >= PIPE_SKIP);
      if (pop_m) begin
        void'(q_data.pop_front());
        void'(q_err.pop_front());
      end
      if (push_m) begin
        if (q_data.size() >= FIFO_DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          q_data.push_back(d);
          q_err.push_back(m_ovf ? 2'b01 : 2'b00);
          m_ovf = 1'b0;
        end
      end
      m_cyc++;
    end
  endtask

  task automatic compareModel();
    logic       ev;
    logic       ec;
    logic [7:0] hd;
    logic [1:0] he;
    ev = (q_data.size() > 0);
    hd = ev ? q_data[0] : 8'h00;
    he = ev ? q_err[0] : 2'b00;
    ec = (m_cyc > 0) && (((m_cyc - 1) % CLK_DIV) < (CLK_DIV / 2));
    checkOutput($sformatf("model_signed@%0d", m_cyc),
      32'({ad_clk_s, ast_s.ast_source_valid,
           ev ? ast_s.ast_source_data : 8'h00, ev ? ast_s.ast_source_error : 2'b00}),
      32'({ec, ev, ev ? (hd ^ 8'h80) : 8'h00, he}));
    checkOutput($sformatf("model_unsigned@%0d", m_cyc),
      32'({ad_clk_u, ast_u.ast_source_valid,
           ev ? ast_u.ast_source_data : 8'h00, ev ? ast_u.ast_source_error : 2'b00}),
      32'({ec, ev, hd, he}));
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic rdy);
    rst     = r;
    ad_data = d;
    ready   = rdy;
    @(posedge clk);
    #1;
    modelStep(r, d, rdy);
    compareModel();
  endtask

  task automatic runTo(input int target, input logic rdy);
    while (m_cyc < target) applyStimulus(1'b0, dval(m_cyc), rdy);
  endtask

  // Drives every phase of the test and prints the summary.
  initial begin
    vec_t tab[11];
    int   n;

    tab[0]  = '{0,  1'b0, 1'b0, 1'b1, 8'h00, 2'b00};
    tab[1]  = '{1,  1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[2]  = '{4,  1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[3]  = '{5,  1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[4]  = '{9,  1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[5]  = '{30, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[6]  = '{31, 1'b0, 1'b1, 1'b1, 8'h00, 2'b00};
    tab[7]  = '{32, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[8]  = '{33, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    tab[9]  = '{39, 1'b0, 1'b1, 1'b1, 8'h00, 2'b00};
    tab[10] = '{40, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};

    rst     = 1'b1;
    ready   = 1'b0;
    ad_data = 8'h00;
    repeat (3) applyStimulus(1'b1, 8'h00, 1'b0);

    $display("[TB] startup timing with AD_Data=80, ready=1");
    for (int i = 0; i < 11; i++) begin
      while (m_cyc < tab[i].cyc) applyStimulus(1'b0, 8'h80, 1'b1);
      checkOutput($sformatf("tab_adclk@%0d", tab[i].cyc), 32'(ad_clk_s), 32'(tab[i].clk_e));
      checkOutput($sformatf("tab_valid@%0d", tab[i].cyc), 32'(ast_s.ast_source_valid), 32'(tab[i].valid_e));
      if (tab[i].chk_data) begin
        checkOutput($sformatf("tab_data@%0d", tab[i].cyc), 32'(ast_s.ast_source_data), 32'(tab[i].data_e));
        checkOutput($sformatf("tab_err@%0d", tab[i].cyc), 32'(ast_s.ast_source_error), 32'(tab[i].err_e));
      end
    end

    $display("[TB] overflow: ready low for six strobes");
    runTo(87, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_drain_data%0d", i), 32'(ast_u.ast_source_data), 32'(dval(46 + 8 * i)));
      checkOutput($sformatf("ovf_drain_err%0d", i), 32'(ast_u.ast_source_error), 32'(2'b00));
      applyStimulus(1'b0, dval(m_cyc), 1'b1);
    end
    checkOutput("ovf_drained_valid", 32'(ast_u.ast_source_valid), 32'(1'b0));
    runTo(95, 1'b1);
    checkOutput("ovf_tagged_data", 32'(ast_u.ast_source_data), 32'(dval(94)));
    checkOutput("ovf_tagged_err", 32'(ast_u.ast_source_error), 32'(2'b01));
    runTo(103, 1'b1);
    checkOutput("ovf_after_data", 32'(ast_u.ast_source_data), 32'(dval(102)));
    checkOutput("ovf_after_err", 32'(ast_u.ast_source_error), 32'(2'b00));
    applyStimulus(1'b0, dval(m_cyc), 1'b1);

    $display("[TB] full buffer with push and pop on the same strobe");
    runTo(142, 1'b0);
    checkOutput("full_head_data", 32'(ast_u.ast_source_data), 32'(dval(110)));
    applyStimulus(1'b0, dval(m_cyc), 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("full_drain_data%0d", i), 32'(ast_u.ast_source_data), 32'(dval(118 + 8 * i)));
      checkOutput($sformatf("full_drain_err%0d", i), 32'(ast_u.ast_source_error), 32'(2'b00));
      applyStimulus(1'b0, dval(m_cyc), 1'b1);
    end
    checkOutput("full_drained_valid", 32'(ast_u.ast_source_valid), 32'(1'b0));
    runTo(151, 1'b1);
    checkOutput("full_next_err", 32'(ast_u.ast_source_error), 32'(2'b00));
    checkOutput("full_next_data", 32'(ast_u.ast_source_data), 32'(dval(150)));

    $display("[TB] randomized stream against model");
    for (int i = 0; i < 1200; i++) begin
      logic rdy;
      case (i / 300)
        0:       rdy = m_cyc[0];
        1:       rdy = ($urandom_range(0, 9) < 3);
        2:       rdy = ($urandom_range(0, 9) < 8);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(1'b0, 8'($urandom), rdy);
    end

    $display("[TB] reset pulse with three words buffered");
    repeat (10) applyStimulus(1'b0, 8'($urandom), 1'b1);
    n = 0;
    while ((q_data.size() < 3) && (n < 100)) begin
      applyStimulus(1'b0, 8'($urandom), 1'b0);
      n++;
    end
    checkOutput("prereset_fill_bound", 32'(n < 100), 32'(1));
    applyStimulus(1'b1, 8'($urandom), 1'b0);
    checkOutput("rst_valid", 32'(ast_s.ast_source_valid), 32'(1'b0));
    checkOutput("rst_data", 32'(ast_s.ast_source_data), 32'(8'h00));
    checkOutput("rst_err", 32'(ast_s.ast_source_error), 32'(2'b00));
    checkOutput("rst_adclk", 32'(ad_clk_s), 32'(1'b0));
    n = 0;
    while (!ast_s.ast_source_valid && (n < 100)) begin
      applyStimulus(1'b0, 8'h80, 1'b1);
      n++;
    end
    checkOutput("rst_first_valid_cycle", 32'(m_cyc), 32'(31));
    checkOutput("rst_first_valid_data", 32'(ast_s.ast_source_data), 32'(8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
